// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl: EHXPLLL dynamic phase sequencer and lock supervisor.
// Optional per-channel position counters: PLL_PHASE_POS_EN.
module pll_phase_ctrl #(
    parameter int NUM_CH     = 2,
    parameter int STEP_PULSE = 4,
    parameter int SETTLE     = 16,
    parameter int LOCK_FILT  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_lock_i,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_ch,
    input  logic                  req_dir,
    input  logic [7:0]            req_steps,
    output logic [1:0]            phasesel,
    output logic                  phasedir,
    output logic                  phasestep,
    output logic                  phaseloadreg,
    output logic                  locked_o,
    output logic                  sys_rst_n,
    output logic                  lock_lost,
    output logic [8*NUM_CH-1:0]   phase_pos_o
);

    localparam int CW   = $clog2(LOCK_FILT);
    localparam int TMAX = (STEP_PULSE > SETTLE) ? STEP_PULSE : SETTLE;
    localparam int TW   = $clog2(TMAX) + 1;

    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_FILT - 1);
    localparam logic [TW-1:0] LO_LAST = TW'(STEP_PULSE - 1);
    localparam logic [TW-1:0] HI_LAST = TW'(SETTLE - 1);

    typedef enum logic [2:0] {
        LOCK_WAIT,
        IDLE,
        SETUP,
        STEP_LO,
        STEP_HI
    } state_e;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          locked_q, locked_d;
    logic          srst_q;
    logic          lost_q;
    logic          drop;

    state_e        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [7:0]    steps_q, steps_d;
    logic [1:0]    ch_q, ch_d;
    logic          dir_q, dir_d;
    logic [1:0]    sel_q, sel_d;
    logic          pdir_q, pdir_d;
    logic          rdy_q, rdy_d;
    logic          pstep_q, pstep_d;
    logic          valid_req;

    // Two-flop synchroniser for the asynchronous PLL lock pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_lock_i};
        end
    end

    // Lock filter: count consecutive high samples, any low sample restarts
    always_comb begin
        cnt_d    = cnt_q;
        locked_d = locked_q;
        if (!sync_q[1]) begin
            cnt_d    = '0;
            locked_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
            locked_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign drop = locked_q & ~locked_d;

    // Lock state, delayed downstream reset and sticky lock-loss flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            locked_q <= 1'b0;
            srst_q   <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            srst_q   <= locked_q;
            lost_q   <= lost_q | drop;
        end
    end

    assign valid_req = (req_steps != 8'd0) &&
                       ({1'b0, req_ch} < 3'(NUM_CH));

    // Step sequencer next state; lock loss overrides everything
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        steps_d = steps_q;
        ch_d    = ch_q;
        dir_d   = dir_q;
        sel_d   = sel_q;
        pdir_d  = pdir_q;
        if (drop) begin
            state_d = LOCK_WAIT;
            steps_d = '0;
            tmr_d   = '0;
        end else begin
            unique case (state_q)
                LOCK_WAIT: begin
                    if (locked_q) begin
                        state_d = IDLE;
                    end
                end
                IDLE: begin
                    if (req_valid && rdy_q && valid_req) begin
                        ch_d    = req_ch;
                        dir_d   = req_dir;
                        steps_d = req_steps;
                        state_d = SETUP;
                    end
                end
                SETUP: begin
                    sel_d   = ch_q;
                    pdir_d  = dir_q;
                    tmr_d   = '0;
                    state_d = STEP_LO;
                end
                STEP_LO: begin
                    if (tmr_q == LO_LAST) begin
                        tmr_d   = '0;
                        state_d = STEP_HI;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                STEP_HI: begin
                    if (tmr_q == HI_LAST) begin
                        tmr_d   = '0;
                        steps_d = steps_q - 1'b1;
                        state_d = (steps_q == 8'd1) ? IDLE : STEP_LO;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                default: begin
                    state_d = LOCK_WAIT;
                end
            endcase
        end
    end

    // Ready only after a full cycle in IDLE; strobe follows STEP_LO a cycle later
    always_comb begin
        rdy_d   = (state_q == IDLE) && (state_d == IDLE);
        pstep_d = !((state_q == STEP_LO) && !drop);
    end

    // Sequencer and PLL pin registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOCK_WAIT;
            tmr_q   <= '0;
            steps_q <= '0;
            ch_q    <= '0;
            dir_q   <= 1'b1;
            sel_q   <= '0;
            pdir_q  <= 1'b1;
            rdy_q   <= 1'b0;
            pstep_q <= 1'b1;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            steps_q <= steps_d;
            ch_q    <= ch_d;
            dir_q   <= dir_d;
            sel_q   <= sel_d;
            pdir_q  <= pdir_d;
            rdy_q   <= rdy_d;
            pstep_q <= pstep_d;
        end
    end

`ifdef PLL_PHASE_POS_EN
    logic                pos_rise;
    logic [8*NUM_CH-1:0] pos_q, pos_d;

    assign pos_rise = pstep_d & ~pstep_q;

    // Net position: +1 lag / -1 lead on each rising strobe, modulo 256
    always_comb begin
        pos_d = pos_q;
        if (pos_rise) begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (sel_q == 2'(n)) begin
                    pos_d[8*n +: 8] = pos_q[8*n +: 8] +
                                      (pdir_q ? 8'h01 : 8'hFF);
                end
            end
        end
    end

    // Position counters survive lock loss; cleared only by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign phase_pos_o = pos_q;
`else
    assign phase_pos_o = '0;
`endif

    assign req_ready    = rdy_q;
    assign phasesel     = sel_q;
    assign phasedir     = pdir_q;
    assign phasestep    = pstep_q;
    assign phaseloadreg = 1'b1;
    assign locked_o     = locked_q;
    assign sys_rst_n    = srst_q;
    assign lock_lost    = lost_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// tb_pll_phase_ctrl: directed vectors for pll_phase_ctrl.
// Positions expected only when PLL_PHASE_POS_EN is defined.
module tb_pll_phase_ctrl;

    localparam int NUM_CH = 2;

`ifdef PLL_PHASE_POS_EN
    localparam bit POS_EN = 1'b1;
`else
    localparam bit POS_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                pll_lock_i = 1'b0;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic [1:0]          req_ch = 2'd0;
    logic                req_dir = 1'b0;
    logic [7:0]          req_steps = 8'd0;
    logic [1:0]          phasesel;
    logic                phasedir;
    logic                phasestep;
    logic                phaseloadreg;
    logic                locked_o;
    logic                sys_rst_n;
    logic                lock_lost;
    logic [8*NUM_CH-1:0] phase_pos_o;

    int npass = 0;
    int ntot  = 0;

    pll_phase_ctrl #(
        .NUM_CH(NUM_CH), .STEP_PULSE(4), .SETTLE(16), .LOCK_FILT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_lock_i(pll_lock_i),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ch(req_ch), .req_dir(req_dir), .req_steps(req_steps),
        .phasesel(phasesel), .phasedir(phasedir),
        .phasestep(phasestep), .phaseloadreg(phaseloadreg),
        .locked_o(locked_o), .sys_rst_n(sys_rst_n),
        .lock_lost(lock_lost), .phase_pos_o(phase_pos_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ch;
        logic       dir;
        logic [7:0] steps;
        int         lat;
        int         pulses;
        logic [7:0] p0;
        logic [7:0] p1;
    } vec_t;

    vec_t vt[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ntot++;
        if (act === exp) begin
            npass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] epos(input logic [7:0] v);
        return POS_EN ? v : 8'h00;
    endfunction

    task automatic wait_ready(input int lim, output bit ok);
        ok = req_ready;
        for (int i = 0; i < lim && !ok; i++) begin
            tick();
            ok = req_ready;
        end
    endtask

    task automatic do_req(input string tag, input logic [1:0] ch,
                          input logic dir, input logic [7:0] st,
                          input int lat, input int pulses);
        int f[$];
        int r[$];
        int c;
        int sbad;
        int wbad;
        int lows;
        int drops;
        int first;
        bit prev;
        bit done;
        req_valid = 1'b1;
        req_ch    = ch;
        req_dir   = dir;
        req_steps = st;
        tick();
        req_valid = 1'b0;
        if (lat == 0) begin
            chk({tag, "_rdy"}, req_ready, 1);
            lows  = 0;
            drops = 0;
            repeat (25) begin
                tick();
                if (!phasestep) lows++;
                if (!req_ready) drops++;
            end
            chk({tag, "_nostep"}, lows, 0);
            chk({tag, "_hold"}, drops, 0);
        end else begin
            chk({tag, "_rdyfall"}, req_ready, 0);
            prev = phasestep;
            done = 1'b0;
            c    = 0;
            sbad = 0;
            while (!done && c < 700) begin
                tick();
                c++;
                if (phasesel !== ch || phasedir !== dir) sbad++;
                if (prev && !phasestep) f.push_back(c);
                if (!prev && phasestep) r.push_back(c);
                prev = phasestep;
                if (req_ready) done = 1'b1;
            end
            chk({tag, "_lat"}, done ? c : -1, lat);
            chk({tag, "_pulses"}, f.size(), pulses);
            first = -1;
            if (f.size() > 0) first = f[0];
            chk({tag, "_first"}, first, 2);
            wbad = 0;
            if (r.size() != f.size() || r.size() == 0) begin
                wbad++;
            end else begin
                for (int k = 0; k < f.size(); k++) begin
                    if (r[k] - f[k] != 4) wbad++;
                    if (k > 0 && f[k] - r[k-1] != 16) wbad++;
                end
                if (c - r[r.size()-1] != 16) wbad++;
            end
            chk({tag, "_timing"}, wbad, 0);
            chk({tag, "_sel"}, sbad, 0);
        end
    endtask

    initial begin
        bit ok;
        int c;
        int dropc;
        int bad;
        int lows;

        vt[0] = '{2'd1, 1'b1, 8'd3, 62, 3, 8'h00, 8'h03};
        vt[1] = '{2'd0, 1'b0, 8'd1, 22, 1, 8'hFF, 8'h03};
        vt[2] = '{2'd0, 1'b1, 8'd0,  0, 0, 8'hFF, 8'h03};
        vt[3] = '{2'd3, 1'b1, 8'd5,  0, 0, 8'hFF, 8'h03};
        vt[4] = '{2'd0, 1'b1, 8'd2, 42, 2, 8'h01, 8'h03};
        vt[5] = '{2'd2, 1'b0, 8'd1,  0, 0, 8'h01, 8'h03};
        vt[6] = '{2'd1, 1'b0, 8'd1, 22, 1, 8'h01, 8'h02};

        #2 rst_n = 1'b0;
        #1;
        chk("rst_outs", {phasesel, phasedir, phasestep, phaseloadreg,
                         req_ready, locked_o, sys_rst_n, lock_lost},
            9'b00_1_1_1_0_0_0_0);
        chk("rst_pos", phase_pos_o, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        pll_lock_i = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i == 5) pll_lock_i = 1'b0;
            if (i == 6) pll_lock_i = 1'b1;
            if (i == 10) chk("glitch_lk10", locked_o, 0);
            if (i == 15) chk("glitch_lk15", locked_o, 0);
            if (i == 16) chk("glitch_lk16", locked_o, 1);
            if (i == 16) chk("glitch_sr16", sys_rst_n, 0);
            if (i == 17) chk("glitch_sr17", sys_rst_n, 1);
        end

        rst_n      = 1'b0;
        pll_lock_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        pll_lock_i = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i == 9)  chk("lock_lk9", locked_o, 0);
            if (i == 10) chk("lock_lk10", locked_o, 1);
            if (i == 10) chk("lock_sr10", sys_rst_n, 0);
            if (i == 11) chk("lock_sr11", sys_rst_n, 1);
        end
        chk("lock_nolost", lock_lost, 0);
        wait_ready(20, ok);
        chk("lock_ready", ok, 1);

        for (int v = 0; v < 7; v++) begin
            wait_ready(40, ok);
            chk($sformatf("v%0d_ready", v), ok, 1);
            do_req($sformatf("v%0d", v), vt[v].ch, vt[v].dir,
                   vt[v].steps, vt[v].lat, vt[v].pulses);
            chk($sformatf("v%0d_pos0", v), phase_pos_o[7:0],
                epos(vt[v].p0));
            chk($sformatf("v%0d_pos1", v), phase_pos_o[15:8],
                epos(vt[v].p1));
        end

        req_valid = 1'b1;
        req_ch    = 2'd1;
        req_dir   = 1'b1;
        req_steps = 8'd0;
        tick();
        chk("b2b_null_rdy", req_ready, 1);
        req_steps = 8'd1;
        tick();
        req_valid = 1'b0;
        chk("b2b_accept", req_ready, 0);
        wait_ready(40, ok);
        chk("b2b_done", ok, 1);
        chk("b2b_pos1", phase_pos_o[15:8], epos(8'h03));

        req_valid = 1'b1;
        req_ch    = 2'd0;
        req_dir   = 1'b1;
        req_steps = 8'd10;
        tick();
        req_valid = 1'b0;
        c     = 0;
        dropc = 0;
        while (c < 40 && dropc == 0) begin
            tick();
            c++;
            if (c == 20) pll_lock_i = 1'b0;
            if (!locked_o) dropc = c;
        end
        chk("ll_dropcyc", dropc, 23);
        tick();
        chk("ll_step_hi", phasestep, 1);
        chk("ll_lost", lock_lost, 1);
        chk("ll_rdy", req_ready, 0);
        bad = 0;
        repeat (10) begin
            tick();
            if (req_ready || !phasestep) bad++;
        end
        chk("ll_hold", bad, 0);
        pll_lock_i = 1'b1;
        wait_ready(30, ok);
        chk("ll_relock", ok, 1);
        chk("ll_sticky", lock_lost, 1);
        chk("ll_pos0", phase_pos_o[7:0], epos(8'h03));
        lows = 0;
        repeat (25) begin
            tick();
            if (!phasestep) lows++;
        end
        chk("ll_discard", lows, 0);

        req_valid = 1'b1;
        req_ch    = 2'd1;
        req_dir   = 1'b1;
        req_steps = 8'd2;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        chk("rst_pre_low", phasestep, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_async", {phasesel, phasedir, phasestep, phaseloadreg,
                          req_ready, locked_o, sys_rst_n, lock_lost},
            9'b00_1_1_1_0_0_0_0);
        chk("rst_async_pos", phase_pos_o, 0);
        tick();
        rst_n = 1'b1;
        bad = 0;
        repeat (6) begin
            tick();
            if (req_ready || !phasestep || locked_o) bad++;
        end
        chk("rst_lockwait", bad, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
